gb_bus_responder: RTL and testbench

- Memory-side responder for the CPU core's bus (address out, data out, write strobe, data in).
- Each M-cycle it decodes the CPU address and serves internal targets: HRAM (FF80-FFFE), IE (FFFF), IF (FF0F) and the OAM DMA register (FF46).
- All other addresses go to the external bus.
- Owns the OAM DMA engine and interrupt-flag latching; produces pending-interrupt vector for the CPU.

---
 rtl/gb_bus_responder.sv | 114 +++++++++++
 tb/tb_gb_bus_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gb_bus_responder.sv
// gb_bus_responder: CPU bus decode for HRAM/IE/IF/FF46, interrupt flag latching and OAM DMA.
// Define GB_BUS_OAM_DMA_EN to build the OAM DMA engine; otherwise FF46 is a plain register.
module gb_bus_responder #(
    parameter int HRAM_DEPTH = 127,
    parameter int DMA_LEN    = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    output logic [7:0]  cpu_data_o,
    output logic [15:0] ext_addr_o,
    output logic [7:0]  ext_data_o,
    output logic        ext_we_o,
    input  logic [7:0]  ext_data_i,
    output logic [7:0]  oam_addr_o,
    output logic [7:0]  oam_data_o,
    output logic        oam_we_o,
    input  logic [4:0]  irq_i,
    input  logic [4:0]  irq_ack_i,
    output logic [4:0]  irq_pending_o,
    output logic        dma_active_o
);
    if (HRAM_DEPTH < 1 || HRAM_DEPTH > 127 || DMA_LEN < 1 || DMA_LEN > 256) begin : g_bad_params
        $error("gb_bus_responder: parameter out of range");
    end

    logic        w_high, w_ie_sel, w_hram_sel, w_if_sel, w_dma_sel, w_int, w_hram_ok;
    logic        w_xfer, w_blk, w_wr;
    logic [6:0]  w_hidx;
    logic [7:0]  w_rdata;
    logic [15:0] w_dma_addr;
    logic [7:0]  r_hram [HRAM_DEPTH];
    logic [7:0]  r_cpu_data, r_ie, r_src;
    logic [4:0]  r_if;

    assign w_high     = cpu_addr_i[15:7] == 9'h1FF;
    assign w_ie_sel   = cpu_addr_i == 16'hFFFF;
    assign w_hram_sel = w_high && !w_ie_sel;
    assign w_if_sel   = cpu_addr_i == 16'hFF0F;
    assign w_dma_sel  = cpu_addr_i == 16'hFF46;
    assign w_int      = w_high || w_if_sel || w_dma_sel;
    assign w_hidx     = cpu_addr_i[6:0];
    assign w_hram_ok  = int'(w_hidx) < HRAM_DEPTH;
    // While DMA owns the external bus only FF80-FFFF and FF46 stay reachable
    assign w_blk      = w_xfer && !w_high && !w_dma_sel;
    assign w_wr       = cpu_we_i && !w_blk;

    assign w_rdata = w_blk      ? 8'hFF :
                     w_ie_sel   ? r_ie :
                     w_hram_sel ? (w_hram_ok ? r_hram[w_hidx] : 8'hFF) :
                     w_if_sel   ? {3'b111, r_if} :
                     w_dma_sel  ? r_src : ext_data_i;

    assign cpu_data_o    = r_cpu_data;
    assign ext_addr_o    = !reset ? 16'h0000 : w_xfer ? w_dma_addr : cpu_addr_i;
    assign ext_data_o    = cpu_data_i;
    assign ext_we_o      = reset && cpu_we_i && !w_int && !w_xfer;
    assign irq_pending_o = r_ie[4:0] & r_if;

    always_ff @(posedge clk)
        if (w_wr && w_hram_sel && w_hram_ok) r_hram[w_hidx] <= cpu_data_i;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_cpu_data <= 8'hFF;
            r_ie       <= 8'h00;
            r_if       <= 5'h00;
            r_src      <= 8'h00;
        end else begin
            r_cpu_data <= w_rdata;
            if (w_wr && w_ie_sel) r_ie <= cpu_data_i;
            if (w_wr && w_dma_sel) r_src <= cpu_data_i;
            r_if <= (((w_wr && w_if_sel) ? cpu_data_i[4:0] : r_if) & ~irq_ack_i) | irq_i;
        end

`ifdef GB_BUS_OAM_DMA_EN
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_idx;

    assign w_xfer       = r_state == XFER;
    assign w_dma_addr   = {r_src, r_idx};
    assign oam_we_o     = w_xfer;
    assign oam_addr_o   = r_idx;
    assign oam_data_o   = ext_data_i;
    assign dma_active_o = w_xfer;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 8'h00;
        end else if (cpu_we_i && w_dma_sel) begin
            r_state <= SETUP;
            r_idx   <= 8'h00;
        end else if (r_state == SETUP) begin
            r_state <= XFER;
        end else if (w_xfer) begin
            r_idx <= r_idx + 8'h01;
            if (r_idx == 8'(DMA_LEN - 1)) r_state <= IDLE;
        end
`else
    assign w_xfer       = 1'b0;
    assign w_dma_addr   = 16'h0000;
    assign oam_we_o     = 1'b0;
    assign oam_addr_o   = 8'h00;
    assign oam_data_o   = 8'h00;
    assign dma_active_o = 1'b0;
`endif
endmodule

// File: tb/tb_gb_bus_responder.sv
// tb_gb_bus_responder: directed checks of decode, HRAM, IE/IF latching, external pass-through and FF46.
module tb_gb_bus_responder;
    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_we_i;
    logic [7:0]  cpu_data_o;
    logic [15:0] ext_addr_o;
    logic [7:0]  ext_data_o;
    logic        ext_we_o;
    logic [7:0]  ext_data_i;
    logic [7:0]  oam_addr_o;
    logic [7:0]  oam_data_o;
    logic        oam_we_o;
    logic [4:0]  irq_i;
    logic [4:0]  irq_ack_i;
    logic [4:0]  irq_pending_o;
    logic        dma_active_o;
    int          checks;
    int          errors;

    gb_bus_responder dut (
        .clk(clk), .reset(reset),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i), .cpu_data_o(cpu_data_o),
        .ext_addr_o(ext_addr_o), .ext_data_o(ext_data_o), .ext_we_o(ext_we_o), .ext_data_i(ext_data_i),
        .oam_addr_o(oam_addr_o), .oam_data_o(oam_data_o), .oam_we_o(oam_we_o),
        .irq_i(irq_i), .irq_ack_i(irq_ack_i), .irq_pending_o(irq_pending_o), .dma_active_o(dma_active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_we_i   = 1'b1;
        tick();
        cpu_we_i   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        cpu_addr_i = a;
        cpu_we_i   = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        cpu_addr_i = 16'h1234;
        cpu_data_i = 8'h99;
        cpu_we_i = 1'b1;
        ext_data_i = 8'h77;
        irq_i = 5'h00;
        irq_ack_i = 5'h00;
        tick();
        check("rst_cpu_data", 16'(cpu_data_o), 16'h00FF);
        check("rst_ext_addr", ext_addr_o, 16'h0000);
        check("rst_ext_we", 16'(ext_we_o), 16'h0000);
        check("rst_oam_we", 16'(oam_we_o), 16'h0000);
        check("rst_dma_active", 16'(dma_active_o), 16'h0000);
        check("rst_pending", 16'(irq_pending_o), 16'h0000);
        cpu_we_i = 1'b0;
        reset = 1'b1;
        tick();
        wr(16'hFF80, 8'hA5);
        rd(16'hFF80);
        check("hram_ff80", 16'(cpu_data_o), 16'h00A5);
        wr(16'hFFFE, 8'h5A);
        rd(16'hFFFE);
        check("hram_fffe", 16'(cpu_data_o), 16'h005A);
        rd(16'hFF80);
        check("hram_ff80_kept", 16'(cpu_data_o), 16'h00A5);
        irq_i = 5'b00100;
        wr(16'hFF0F, 8'h00);
        irq_i = 5'h00;
        rd(16'hFF0F);
        check("if_set_beats_write", 16'(cpu_data_o), 16'h00E4);
        wr(16'hFFFF, 8'h04);
        check("pending_ie04", 16'(irq_pending_o), 16'h0004);
        rd(16'hFFFF);
        check("ie_read", 16'(cpu_data_o), 16'h0004);
        irq_ack_i = 5'b00100;
        tick();
        irq_ack_i = 5'h00;
        check("pending_after_ack", 16'(irq_pending_o), 16'h0000);
        irq_i = 5'b00001;
        irq_ack_i = 5'b00001;
        tick();
        irq_i = 5'h00;
        irq_ack_i = 5'h00;
        rd(16'hFF0F);
        check("if_set_beats_ack", 16'(cpu_data_o), 16'h00E1);
        wr(16'hFF0F, 8'hFF);
        check("pending_if_write", 16'(irq_pending_o), 16'h0004);
        rd(16'hFF0F);
        check("if_read_all", 16'(cpu_data_o), 16'h00FF);
        cpu_addr_i = 16'h8000;
        cpu_data_i = 8'h3C;
        cpu_we_i = 1'b1;
        #1;
        check("ext_wr_addr", ext_addr_o, 16'h8000);
        check("ext_wr_data", 16'(ext_data_o), 16'h003C);
        check("ext_wr_we", 16'(ext_we_o), 16'h0001);
        cpu_addr_i = 16'hFF81;
        #1;
        check("int_wr_no_ext_we", 16'(ext_we_o), 16'h0000);
        tick();
        cpu_we_i = 1'b0;
        ext_data_i = 8'h77;
        rd(16'hC000);
        check("ext_rd_c000", 16'(cpu_data_o), 16'h0077);
        ext_data_i = 8'h12;
        rd(16'h8000);
        check("ext_rd_8000", 16'(cpu_data_o), 16'h0012);
`ifdef GB_BUS_OAM_DMA_EN
        wr(16'hFF46, 8'hC1);
        check("dma_setup_inactive", 16'(dma_active_o), 16'h0000);
        tick();
        cpu_addr_i = 16'hC000;
        for (int i = 0; i < 160; i++) begin
            ext_data_i = 8'(i) ^ 8'h5A;
            #1;
            check("dma_ext_addr", ext_addr_o, {8'hC1, 8'(i)});
            check("dma_oam_addr", 16'(oam_addr_o), 16'(i));
            check("dma_oam_data", 16'(oam_data_o), 16'(8'(i) ^ 8'h5A));
            check("dma_oam_we", 16'(oam_we_o), 16'h0001);
            check("dma_active", 16'(dma_active_o), 16'h0001);
            tick();
            check("dma_cpu_rd_blocked", 16'(cpu_data_o), 16'h00FF);
        end
        check("dma_done_inactive", 16'(dma_active_o), 16'h0000);
        check("dma_done_oam_we", 16'(oam_we_o), 16'h0000);
        rd(16'hFF46);
        check("dma_reg_read", 16'(cpu_data_o), 16'h00C1);
        wr(16'hFF46, 8'hC1);
        tick();
        repeat (50) tick();
        check("dma_idx50", 16'(oam_addr_o), 16'h0032);
        wr(16'hFF46, 8'hD0);
        check("dma_restart_setup", 16'(dma_active_o), 16'h0000);
        tick();
        check("dma_restart_addr", ext_addr_o, 16'hD000);
        check("dma_restart_idx", 16'(oam_addr_o), 16'h0000);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("dma_abort_oam_we", 16'(oam_we_o), 16'h0000);
        check("dma_abort_active", 16'(dma_active_o), 16'h0000);
        reset = 1'b1;
        tick();
`else
        ext_data_i = 8'h77;
        wr(16'hFF46, 8'hC1);
        for (int i = 0; i < 3; i++) begin
            check("ff46_no_oam_we", 16'(oam_we_o), 16'h0000);
            check("ff46_no_dma_active", 16'(dma_active_o), 16'h0000);
            tick();
        end
        rd(16'hFF46);
        check("ff46_readback", 16'(cpu_data_o), 16'h00C1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
